// File: rtl/add36_pipe.sv
// add36_pipe: 2-stage 36-bit adder built from two cs18 carry-select slices; 2-cycle latency.
// Stalls when the output is held; in_ready_o drops only with both stages full. Optional ovf_o: ADD36_OVF_EN.

// cs18: 18-bit carry-select slice, combinational; carry out is active-low.
module cs18 (
  input  logic [17:0] a_i,
  input  logic [17:0] b_i,
  input  logic        ci_i,
  output logic [17:0] s_o,
  output logic        co_n_o
);
  logic [9:0] w_lo;
  logic [9:0] w_hi0;
  logic [9:0] w_hi1;
  logic [9:0] w_hi;

  assign w_lo   = {1'b0, a_i[8:0]} + {1'b0, b_i[8:0]} + {9'd0, ci_i};
  // Upper 9 bits are precomputed for both carry-in values and picked by the low carry.
  assign w_hi0  = {1'b0, a_i[17:9]} + {1'b0, b_i[17:9]};
  assign w_hi1  = {1'b0, a_i[17:9]} + {1'b0, b_i[17:9]} + 10'd1;
  assign w_hi   = w_lo[9] ? w_hi1 : w_hi0;
  assign s_o    = {w_hi[8:0], w_lo[8:0]};
  assign co_n_o = ~w_hi[9];
endmodule

// Purpose: {cout_o, sum_o} = a_i + b_i + cin_i with a saturating completed-op count.
// Latency: 2 cycles, one op per clock sustained.
// Backpressure: out_ready_i low holds the output; stage 1 holds when full.
module add36_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [35:0]      a_i,
  input  logic [35:0]      b_i,
  input  logic             cin_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [35:0]      sum_o,
  output logic             cout_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef ADD36_OVF_EN
  output logic             ovf_o,
`endif
  output logic [CNT_W-1:0] done_cnt_o
);
  logic        r_s1_valid;
  logic [17:0] r_s1_a_hi;
  logic [17:0] r_s1_b_hi;
  logic [17:0] r_s1_sum_lo;
  logic        r_s1_c18;

  logic        w_adv1;
  logic        w_adv2;
  logic [17:0] w_lo_sum;
  logic        w_lo_co_n;
  logic [17:0] w_hi_sum;
  logic        w_hi_co_n;
  logic        w_xfer_out;

  assign w_adv2     = ~out_valid_o | out_ready_i;
  assign w_adv1     = ~r_s1_valid | w_adv2;
  assign in_ready_o = w_adv1;
  assign w_xfer_out = out_valid_o & out_ready_i;

  cs18 u_lo (
    .a_i    (a_i[17:0]),
    .b_i    (b_i[17:0]),
    .ci_i   (cin_i),
    .s_o    (w_lo_sum),
    .co_n_o (w_lo_co_n)
  );

  cs18 u_hi (
    .a_i    (r_s1_a_hi),
    .b_i    (r_s1_b_hi),
    .ci_i   (r_s1_c18),
    .s_o    (w_hi_sum),
    .co_n_o (w_hi_co_n)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_a_hi   <= '0;
      r_s1_b_hi   <= '0;
      r_s1_sum_lo <= '0;
      r_s1_c18    <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_a_hi   <= a_i[35:18];
        r_s1_b_hi   <= b_i[35:18];
        r_s1_sum_lo <= w_lo_sum;
        r_s1_c18    <= ~w_lo_co_n;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
`ifdef ADD36_OVF_EN
      ovf_o       <= 1'b0;
`endif
    end else if (w_adv2) begin
      out_valid_o <= r_s1_valid;
      if (r_s1_valid) begin
        sum_o  <= {w_hi_sum, r_s1_sum_lo};
        cout_o <= ~w_hi_co_n;
`ifdef ADD36_OVF_EN
        // Sign bits of both operands travel in the top bit of the stage-1 high halves.
        ovf_o  <= (r_s1_a_hi[17] == r_s1_b_hi[17]) & (w_hi_sum[17] != r_s1_a_hi[17]);
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_cnt_o <= '0;
    end else if (w_xfer_out && (done_cnt_o != {CNT_W{1'b1}})) begin
      done_cnt_o <= done_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_add36_pipe.sv
// Bench for add36_pipe: vector table, hand-written stall/reset sequences, and a
// randomized stream scored against a transaction-level model (queue of expected results).
module tb_add36_pipe;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [35:0]   a_i, b_i;
  logic          cin_i, in_valid_i, in_ready_o;
  logic [35:0]   sum_o;
  logic          cout_o, out_valid_o, out_ready_i;
  logic [CW-1:0] done_cnt_o;
`ifdef ADD36_OVF_EN
  logic          ovf_o;
`endif

  always #5 clk_i = ~clk_i;

  add36_pipe #(.CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
`ifdef ADD36_OVF_EN
    .ovf_o       (ovf_o),
`endif
    .done_cnt_o  (done_cnt_o)
  );

  typedef struct {
    logic [35:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;

  typedef struct {
    logic [35:0] a;
    logic [35:0] b;
    logic        c;
    logic [35:0] s;
    logic        co;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   cyc = 0;
  int   pops = 0;
  int   accepted = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [35:0] a, input logic [35:0] b, input logic c, input int t);
    logic [36:0] r;
    exp_t e;
    r = {1'b0, a} + {1'b0, b} + {36'd0, c};
    e.sum  = r[35:0];
    e.cout = r[36];
    e.ovf  = (a[35] == b[35]) && (r[35] != a[35]);
    e.t    = t;
    return e;
  endfunction

  // One clock: entered and left at a falling edge; outputs sampled 1 time unit after driving.
  task automatic cycle(input logic iv, input logic [35:0] a, input logic [35:0] b,
                       input logic c, input logic ordy);
    exp_t e;
    int   sat;
    in_valid_i  = iv;
    a_i         = a;
    b_i         = b;
    cin_i       = c;
    out_ready_i = ordy;
    #1;
    sat = (pops > MAXC) ? MAXC : pops;
    chk("done_cnt", 64'(done_cnt_o), 64'(sat));
    chk("in_ready", 64'(in_ready_o), 64'((q.size() < 2) || ordy));
    chk("out_valid", 64'(out_valid_o), 64'((q.size() > 0) && (cyc - q[0].t >= 2)));
    if (out_valid_o && ordy) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_result: got sum %0h expected no result", sum_o);
      end else begin
        e = q.pop_front();
        chk("result_sum", 64'(sum_o), 64'(e.sum));
        chk("result_cout", 64'(cout_o), 64'(e.cout));
`ifdef ADD36_OVF_EN
        chk("result_ovf", 64'(ovf_o), 64'(e.ovf));
`endif
        pops++;
      end
    end
    if (iv && in_ready_o) begin
      q.push_back(model(a, b, c, cyc));
      accepted++;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 36'd0, 36'd0, 1'b0, ordy);
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_sum", 64'(sum_o), 64'd0);
    chk("rst_cout", 64'(cout_o), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
`ifdef ADD36_OVF_EN
    chk("rst_ovf", 64'(ovf_o), 64'd0);
`endif
    q.delete();
    pops = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic logic [35:0] pick();
    logic [35:0] v;
    case ($urandom_range(0, 7))
      0:       v = 36'hF_FFFF_FFFF;
      1:       v = 36'h7_FFFF_FFFF;
      2:       v = 36'h0_0003_FFFF;
      default: v = 36'({$urandom(), $urandom()});
    endcase
    return v;
  endfunction

  vec_t tbl[8];

  initial begin
    logic [35:0] s_hold;
    logic [35:0] ra, rb;
    int          acc0;
    int          budget;

    tbl[0] = '{36'h0_0003_FFFF, 36'h0_0000_0001, 1'b0, 36'h0_0004_0000, 1'b0};
    tbl[1] = '{36'hF_FFFF_FFFF, 36'h0_0000_0000, 1'b1, 36'h0_0000_0000, 1'b1};
    tbl[2] = '{36'h0_0000_0000, 36'h0_0000_0000, 1'b0, 36'h0_0000_0000, 1'b0};
    tbl[3] = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1, 36'hF_FFFF_FFFF, 1'b1};
    tbl[4] = '{36'h0_0000_01FF, 36'h0_0000_0001, 1'b0, 36'h0_0000_0200, 1'b0};
    tbl[5] = '{36'h1_2345_6789, 36'h0_1111_1111, 1'b0, 36'h1_3456_789A, 1'b0};
    tbl[6] = '{36'h8_0000_0000, 36'h8_0000_0000, 1'b0, 36'h0_0000_0000, 1'b1};
    tbl[7] = '{36'h0_0003_FFFF, 36'h0_0000_0000, 1'b1, 36'h0_0004_0000, 1'b0};

    rst_ni      = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    a_i         = '0;
    b_i         = '0;
    cin_i       = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Directed vectors, one at a time: result exactly 2 cycles after issue.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1);
      idle(1'b1);
      #1;
      chk("vec_out_valid", 64'(out_valid_o), 64'd1);
      chk("vec_sum", 64'(sum_o), 64'(tbl[i].s));
      chk("vec_cout", 64'(cout_o), 64'(tbl[i].co));
    end
    idle(1'b1);
    chk("vec_done_cnt", 64'(done_cnt_o), 64'(8));

    // Back-to-back issue with the consumer always ready.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(k < 4, pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
    end
    chk("b2b_all_out", 64'(pops), 64'd4);

    // Consumer stalls while 3 ops are offered; only 2 fit.
    do_reset();
    acc0 = accepted;
    cycle(1'b1, 36'h0_0000_0011, 36'h0_0000_0022, 1'b0, 1'b0);
    cycle(1'b1, 36'h0_0000_0033, 36'h0_0000_0044, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      s_hold = sum_o;
      cycle(1'b1, 36'h0_0000_0055, 36'h0_0000_0066, 1'b0, 1'b0);
      chk("stall_sum_hold", 64'(sum_o), 64'(s_hold));
    end
    chk("stall_accepted", 64'(accepted - acc0), 64'd2);
    budget = 0;
    while (((accepted - acc0) < 3 || q.size() != 0) && budget < 20) begin
      cycle((accepted - acc0) < 3, 36'h0_0000_0055, 36'h0_0000_0066, 1'b0, 1'b1);
      budget++;
    end
    chk("stall_drained", 64'(q.size()), 64'd0);
    chk("stall_all_out", 64'(pops), 64'd3);

    // Randomized stream; counter saturates at MAXC along the way.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      ra = pick();
      rb = pick();
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      idle(1'b1);
      budget++;
    end
    chk("rand_drained", 64'(q.size()), 64'd0);

    // Reset with two operations in flight.
    cycle(1'b1, 36'h0_0000_0001, 36'h0_0000_0002, 1'b0, 1'b0);
    cycle(1'b1, 36'h0_0000_0003, 36'h0_0000_0004, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
    chk("midrst_done_cnt", 64'(done_cnt_o), 64'd0);
    q.delete();
    pops = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) idle(1'b1);

`ifdef ADD36_OVF_EN
    do_reset();
    cycle(1'b1, 36'h7_FFFF_FFFF, 36'h0_0000_0001, 1'b0, 1'b1);
    idle(1'b1);
    #1;
    chk("ovf_sum", 64'(sum_o), 64'h8_0000_0000);
    chk("ovf_set", 64'(ovf_o), 64'd1);
    cycle(1'b1, 36'h0_0000_0001, 36'h0_0000_0001, 1'b0, 1'b1);
    idle(1'b1);
    #1;
    chk("ovf_clear", 64'(ovf_o), 64'd0);
    idle(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
